// File: rtl/predict_pkg.sv
// rtl/predict_pkg.sv - shared counter type and update rule for the fetch predictor
package predict_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_cnt_t;

    localparam pht_cnt_t PHT_RESET = WNT;

    // Two-bit saturating step toward the observed outcome.
    function automatic pht_cnt_t cnt_update(input pht_cnt_t cnt, input logic taken);
        pht_cnt_t nxt;
        nxt = cnt;
        case (cnt)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = PHT_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pattern_history_table.sv
// rtl/pattern_history_table.sv - table of 2-bit counters, async read, trained at the clock edge
module pattern_history_table
    import predict_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output pht_cnt_t            rd_cnt_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_taken_i
);

    localparam int ENTRIES = 1 << IDX_BITS;

    pht_cnt_t table_q [ENTRIES];

    // Read sees the pre-edge contents even when the same entry is being trained.
    assign rd_cnt_o = table_q[rd_idx_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= PHT_RESET;
            end
        end else if (wr_en_i) begin
            table_q[wr_idx_i] <= cnt_update(table_q[wr_idx_i], wr_taken_i);
        end
    end

endmodule

// File: rtl/fetch_predictor.sv
// rtl/fetch_predictor.sv - fetch PC sequencer with bimodal prediction and EX-side redirect
module fetch_predictor
    import predict_pkg::*;
#(
    parameter int          PHT_IDX_BITS = 6,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    input  logic        dec_is_branch_i,
    input  logic        dec_is_jump_i,
    input  logic [31:0] dec_target_i,
    input  logic [31:0] dec_pc_plus_4_i,
    output logic        pred_taken_o,
    input  logic        res_valid_i,
    input  logic        res_is_branch_i,
    input  logic        res_is_jr_i,
    input  logic [31:0] res_pc_i,
    input  logic        res_taken_i,
    input  logic        res_pred_taken_i,
    input  logic [31:0] res_target_i,
    output logic        flush_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;
    logic [31:0] pred_next;
    logic [31:0] redirect_pc;
    logic        mispredict;
    logic        train_en;
    pht_cnt_t    rd_cnt;

    assign train_en = res_valid_i & res_is_branch_i;

    pattern_history_table #(
        .IDX_BITS(PHT_IDX_BITS)
    ) u_pht (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (pc_q[PHT_IDX_BITS+1:2]),
        .rd_cnt_o   (rd_cnt),
        .wr_en_i    (train_en),
        .wr_idx_i   (res_pc_i[PHT_IDX_BITS+1:2]),
        .wr_taken_i (res_taken_i)
    );

    assign pred_taken_o = dec_is_jump_i | (dec_is_branch_i & rd_cnt[1]);
    assign pred_next    = pred_taken_o ? dec_target_i : dec_pc_plus_4_i;

    // jr targets are never predicted, so every resolved jr redirects.
    assign mispredict = res_valid_i &
                        ((res_is_branch_i & (res_taken_i != res_pred_taken_i)) | res_is_jr_i);

    always_comb begin
        redirect_pc = res_pc_i + 32'd4;
        if (res_is_jr_i || res_taken_i) begin
            redirect_pc = res_target_i;
        end
    end

    always_comb begin
        pc_d          = pred_next;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (mispredict) begin
            pc_d = redirect_pc;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
        if (res_valid_i && (res_is_branch_i || res_is_jr_i) && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pc_q          <= pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pc_o          = pc_q;
    assign flush_o       = mispredict;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_predictor.sv
// tb/tb_fetch_predictor.sv - directed self-checking bench for fetch_predictor
module tb_fetch_predictor;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic [31:0] pc_o;
    logic        dec_is_branch_i;
    logic        dec_is_jump_i;
    logic [31:0] dec_target_i;
    logic [31:0] dec_pc_plus_4_i;
    logic        pred_taken_o;
    logic        res_valid_i;
    logic        res_is_branch_i;
    logic        res_is_jr_i;
    logic [31:0] res_pc_i;
    logic        res_taken_i;
    logic        res_pred_taken_i;
    logic [31:0] res_target_i;
    logic        flush_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int tests = 0;
    int fails = 0;

    fetch_predictor #(
        .PHT_IDX_BITS(6),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .pc_o             (pc_o),
        .dec_is_branch_i  (dec_is_branch_i),
        .dec_is_jump_i    (dec_is_jump_i),
        .dec_target_i     (dec_target_i),
        .dec_pc_plus_4_i  (dec_pc_plus_4_i),
        .pred_taken_o     (pred_taken_o),
        .res_valid_i      (res_valid_i),
        .res_is_branch_i  (res_is_branch_i),
        .res_is_jr_i      (res_is_jr_i),
        .res_pc_i         (res_pc_i),
        .res_taken_i      (res_taken_i),
        .res_pred_taken_i (res_pred_taken_i),
        .res_target_i     (res_target_i),
        .flush_o          (flush_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        dec_is_branch_i  = 1'b0;
        dec_is_jump_i    = 1'b0;
        dec_target_i     = 32'h0;
        dec_pc_plus_4_i  = 32'h0;
        res_valid_i      = 1'b0;
        res_is_branch_i  = 1'b0;
        res_is_jr_i      = 1'b0;
        res_pc_i         = 32'h0;
        res_taken_i      = 1'b0;
        res_pred_taken_i = 1'b0;
        res_target_i     = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic br, input logic jmp, input logic [31:0] tgt);
        dec_is_branch_i = br;
        dec_is_jump_i   = jmp;
        dec_target_i    = tgt;
        dec_pc_plus_4_i = pc + 32'd4;
    endtask

    task automatic resolve(input logic br, input logic jr, input logic [31:0] pc,
                           input logic taken, input logic pred, input logic [31:0] tgt);
        res_valid_i      = 1'b1;
        res_is_branch_i  = br;
        res_is_jr_i      = jr;
        res_pc_i         = pc;
        res_taken_i      = taken;
        res_pred_taken_i = pred;
        res_target_i     = tgt;
    endtask

    initial begin
        clr();
        stall_i = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_bcnt", branch_cnt_o, 32'h0);
        chk("reset_mcnt", mispred_cnt_o, 32'h0);
        fetch(32'h0, 1'b1, 1'b0, 32'h100);
        #1 chk("reset_pred_wnt", {31'b0, pred_taken_o}, 32'h0);

        // sequential fetch
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4), 1'b0, 1'b0, 32'h0);
            tick();
            chk("seq_pc", pc_o, 32'((i + 1) * 4));
        end

        // jump predicted taken
        fetch(32'h10, 1'b0, 1'b1, 32'h400);
        #1 chk("jump_pred", {31'b0, pred_taken_o}, 32'h1);
        chk("jump_noflush", {31'b0, flush_o}, 32'h0);
        tick();
        chk("jump_pc", pc_o, 32'h400);

        fetch(32'h400, 1'b0, 1'b1, 32'h20);
        tick();
        chk("to_0x20", pc_o, 32'h20);
        fetch(32'h20, 1'b1, 1'b0, 32'h80);
        #1 chk("br_first_pred", {31'b0, pred_taken_o}, 32'h0);
        tick();
        chk("br_fallthru", pc_o, 32'h24);

        // resolve taken, mispredicted; dec jump must be ignored
        fetch(32'h24, 1'b0, 1'b1, 32'h999);
        resolve(1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 32'h80);
        #1 chk("mp_flush", {31'b0, flush_o}, 32'h1);
        tick();
        clr();
        chk("mp_pc", pc_o, 32'h80);
        chk("mp_mcnt", mispred_cnt_o, 32'h1);
        chk("mp_bcnt", branch_cnt_o, 32'h1);

        fetch(32'h80, 1'b0, 1'b1, 32'h20);
        tick();
        fetch(32'h20, 1'b1, 1'b0, 32'h80);
        #1 chk("refetch_pred", {31'b0, pred_taken_o}, 32'h1);

        // saturate toward ST while stalled at 0x20
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            resolve(1'b1, 1'b0, 32'h20, 1'b1, 1'b1, 32'h80);
            #1 chk("sat_noflush", {31'b0, flush_o}, 32'h0);
            tick();
        end
        chk("stall_hold", pc_o, 32'h20);
        chk("sat_bcnt", branch_cnt_o, 32'h4);
        chk("sat_mcnt", mispred_cnt_o, 32'h1);

        // one not-taken from ST: mispredict overrides stall, read is old value
        resolve(1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 32'h80);
        #1 chk("nb_pred_old", {31'b0, pred_taken_o}, 32'h1);
        chk("nt_flush", {31'b0, flush_o}, 32'h1);
        tick();
        clr();
        stall_i = 1'b0;
        chk("nt_pc", pc_o, 32'h24);
        chk("nt_mcnt", mispred_cnt_o, 32'h2);
        fetch(32'h24, 1'b0, 1'b1, 32'h20);
        tick();
        fetch(32'h20, 1'b1, 1'b0, 32'h80);
        #1 chk("wt_pred", {31'b0, pred_taken_o}, 32'h1);
        tick();
        chk("wt_follow", pc_o, 32'h80);

        // valid with no flags: no effect
        fetch(32'h80, 1'b0, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h777);
        #1 chk("noflag_flush", {31'b0, flush_o}, 32'h0);
        tick();
        clr();
        chk("noflag_pc", pc_o, 32'h84);
        chk("noflag_bcnt", branch_cnt_o, 32'h5);

        // mispredict under stall
        stall_i = 1'b1;
        fetch(32'h84, 1'b0, 1'b1, 32'h999);
        resolve(1'b1, 1'b0, 32'h30, 1'b0, 1'b1, 32'h500);
        #1 chk("stall_mp_flush", {31'b0, flush_o}, 32'h1);
        tick();
        clr();
        stall_i = 1'b0;
        chk("stall_mp_pc", pc_o, 32'h34);
        chk("stall_mp_mcnt", mispred_cnt_o, 32'h3);

        // redirect pc+4 wraps
        resolve(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h500);
        tick();
        clr();
        chk("wrap_pc", pc_o, 32'h0);

        // jr: always mispredict, never trains (taken=0 would drop WT to WNT)
        resolve(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h1234);
        #1 chk("jr_flush", {31'b0, flush_o}, 32'h1);
        tick();
        clr();
        chk("jr_pc", pc_o, 32'h1234);
        chk("jr_bcnt", branch_cnt_o, 32'h8);
        chk("jr_mcnt", mispred_cnt_o, 32'h5);
        fetch(32'h1234, 1'b0, 1'b1, 32'h20);
        tick();
        fetch(32'h20, 1'b1, 1'b0, 32'h80);
        #1 chk("jr_notrain", {31'b0, pred_taken_o}, 32'h1);

        // push entry back to ST, then reset during a jr redirect
        stall_i = 1'b1;
        resolve(1'b1, 1'b0, 32'h20, 1'b1, 1'b1, 32'h80);
        tick();
        stall_i = 1'b0;
        resolve(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h1234);
        reset = 1'b1;
        #1 chk("rst_jr_flush", {31'b0, flush_o}, 32'h1);
        tick();
        reset = 1'b0;
        clr();
        chk("rst_jr_pc", pc_o, 32'h0);
        chk("rst_jr_bcnt", branch_cnt_o, 32'h0);
        chk("rst_jr_mcnt", mispred_cnt_o, 32'h0);
        fetch(32'h0, 1'b0, 1'b1, 32'h20);
        tick();
        fetch(32'h20, 1'b1, 1'b0, 32'h80);
        #1 chk("rst_pht_wnt", {31'b0, pred_taken_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_predictor.md
Name: fetch_predictor

Overview:
Fetch-stage PC sequencer and bimodal branch predictor for the pipelined MIPS core.
- Owns the PC register and presents the fetch PC to instruction memory.
- Consumes the combinational pre-decode of the fetched instruction (branch/jump flags, target, PC+4) and chooses the next PC using a table of 2-bit saturating counters.
- Accepts branch/jr resolution from EX: trains the counters, detects mispredicts, redirects the PC and raises flush.

Parameters:
PHT_IDX_BITS, 6, log2 of counter-table entries; index is pc[PHT_IDX_BITS+1:2]
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
stall_i  in  1  hazard unit: hold PC this cycle
pc_o  out  32  current fetch PC (registered)
dec_is_branch_i  in  1  fetched instr is beq/bne
dec_is_jump_i  in  1  fetched instr is j/jal
dec_target_i  in  32  pre-decoded branch/jump target
dec_pc_plus_4_i  in  32  pc_o + 4 from pre-decode
pred_taken_o  out  1  prediction for instr at pc_o, piped down to EX
res_valid_i  in  1  EX resolving a control instr this cycle
res_is_branch_i  in  1  resolved instr is beq/bne
res_is_jr_i  in  1  resolved instr is jr
res_pc_i  in  32  PC of resolved instr
res_taken_i  in  1  actual branch outcome
res_pred_taken_i  in  1  pred_taken carried with the instr
res_target_i  in  32  actual target (branch target or jr register)
flush_o  out  1  squash IF/ID younger instrs (combinational)
branch_cnt_o  out  32  resolved branches + jr count
mispred_cnt_o  out  32  mispredict count

Behaviour:
- Reset (clk edge with reset=1): pc_o=RESET_PC; all counters=WNT (2'b01); branch_cnt_o=0; mispred_cnt_o=0. Reset overrides every other input.
- pred_taken_o (combinational) = dec_is_jump_i | (dec_is_branch_i & pht[pc_o idx][1]).
- pred_next = pred_taken_o ? dec_target_i : dec_pc_plus_4_i.
- Mispredict (combinational) when res_valid_i and either:
  - res_is_branch_i & (res_taken_i != res_pred_taken_i), or
  - res_is_jr_i (always treated as a mispredict).
- redirect_pc:
  - branch: res_taken_i ? res_target_i : res_pc_i+4
  - jr: res_target_i
- flush_o = mispredict (same cycle, no latency).
- PC update priority at each edge: reset > mispredict (pc<=redirect_pc) > stall_i (hold) > pred_next.
  - Mispredict overrides stall_i.
  - pc+4 wraps modulo 2^32.
- Counter training: on res_valid_i & res_is_branch_i, entry res_pc_i[PHT_IDX_BITS+1:2]:
  - res_taken_i: +1, saturating at ST.
  - otherwise: -1, saturating at SNT.
  - Write takes effect at the edge.
  - Read of the same index in the same cycle returns the old value (no bypass).
  - Training is independent of stall_i.
  - jr never trains.
- Statistics:
  - branch_cnt_o += 1 on res_valid_i & (res_is_branch_i | res_is_jr_i).
  - mispred_cnt_o += 1 on mispredict.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- res_valid_i with neither flag set: no effect.
- dec_* inputs are ignored while stall_i is high or a mispredict is in progress.
- Reset asserted mid-redirect: reset wins; counters are reinitialised.

Decomposition:
- Package predict_pkg:
  - pht_cnt_t enum: SNT=0, WNT=1, WT=2, ST=3.
  - PHT_RESET=WNT.
  - function cnt_update(pht_cnt_t, logic taken).
- Sub-module pattern_history_table:
  - 2^PHT_IDX_BITS x pht_cnt_t.
  - 1 async read port, 1 sync write port, sync reset to PHT_RESET.

Test Plan:
1. reset=1 one cycle, RESET_PC=0 -> pc_o=0, counters=0, pred_taken_o=0. Then no ctrl instrs, no stall -> pc_o=0,4,8,C on successive cycles.
2. Jump: at pc_o=0x10, dec_is_jump_i=1, dec_target_i=0x400 -> pred_taken_o=1, next pc_o=0x400, no flush.
3. Branch training: branch at 0x20, counter WNT.
   - First fetch predicts not-taken, pc->0x24.
   - Resolve taken (target 0x80, pred 0) -> flush_o=1, next pc_o=0x80, counter WT, mispred_cnt_o=1.
   - Refetch 0x20 -> pred_taken_o=1.
4. Saturation: resolve 0x20 taken x3 -> counter stays ST. Then one not-taken -> WT, still predicts taken.
5. Mispredict with stall_i=1, resolve not-taken branch at 0x30 with pred_taken=1 -> flush_o=1, next pc_o=0x34 despite stall.
6. jr resolve res_target_i=0x1234 with stall_i=0 -> flush_o=1, pc_o=0x1234, branch_cnt_o and mispred_cnt_o both +1, no counter written. Reset asserted the same cycle -> pc_o=RESET_PC, counts=0.
